// File: rtl/traffic_display.sv
`default_nettype none
// traffic_display: renders the controller's countdown on a 3-digit multiplexed
// 7-segment display plus lamp LEDs; binary-to-BCD is serial double-dabble.
module traffic_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] timee,
  input  logic [1:0] light,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       led_green,
  output logic       led_yellow,
  output logic       led_red,
  output logic       err
);

  localparam int         CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_E = 7'b1111001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_init, w_init_nxt;
  logic [7:0]  r_last_val, w_last_nxt;
  logic [19:0] r_sh, w_sh_nxt, w_adj;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_hund, r_tens, r_ones;
  logic [3:0]  w_hund_nxt, w_tens_nxt, w_ones_nxt;
  logic [CW-1:0] r_scan;
  logic [1:0]  r_digit;
  logic        w_scan_wrap;
  logic [3:0]  w_dval;
  logic        w_blank;
  logic [6:0]  w_pat, w_seg_nxt;
  logic [2:0]  w_an_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Shift register layout: {hund[19:16], tens[15:12], ones[11:8], bin[7:0]}
  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init;
    w_last_nxt  = r_last_val;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_hund_nxt  = r_hund;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_adj       = r_sh;
    if (r_sh[11:8]  >= 4'd5) w_adj[11:8]  = r_sh[11:8]  + 4'd3;
    if (r_sh[15:12] >= 4'd5) w_adj[15:12] = r_sh[15:12] + 4'd3;
    if (r_sh[19:16] >= 4'd5) w_adj[19:16] = r_sh[19:16] + 4'd3;
    case (r_state)
      S_IDLE: begin
        if (r_init || (timee != r_last_val)) begin
          w_sh_nxt    = {12'd0, timee};
          w_last_nxt  = timee;
          w_init_nxt  = 1'b0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        w_sh_nxt  = w_adj << 1;
        w_cnt_nxt = r_cnt + 3'd1;
        if (r_cnt == 3'd7) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_hund_nxt  = r_sh[19:16];
        w_tens_nxt  = r_sh[15:12];
        w_ones_nxt  = r_sh[11:8];
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_scan_wrap = (r_scan == CW'(SCAN_DIV - 1));

  always_comb begin
    w_dval   = r_ones;
    w_blank  = 1'b0;
    w_an_nxt = 3'b001;
    case (r_digit)
      2'd1: begin
        w_dval   = r_tens;
        w_blank  = (r_hund == 4'd0) && (r_tens == 4'd0);
        w_an_nxt = 3'b010;
      end
      2'd2: begin
        w_dval   = r_hund;
        w_blank  = (r_hund == 4'd0);
        w_an_nxt = 3'b100;
      end
      default: ;
    endcase
    case (w_dval)
      4'd0:    w_pat = 7'b0111111;
      4'd1:    w_pat = 7'b0000110;
      4'd2:    w_pat = 7'b1011011;
      4'd3:    w_pat = 7'b1001111;
      4'd4:    w_pat = 7'b1100110;
      4'd5:    w_pat = 7'b1101101;
      4'd6:    w_pat = 7'b1111101;
      4'd7:    w_pat = 7'b0000111;
      4'd8:    w_pat = 7'b1111111;
      4'd9:    w_pat = 7'b1101111;
      default: w_pat = 7'b0000000;
    endcase
    if (light == 2'b11)  w_seg_nxt = SEG_E;
    else if (w_blank)    w_seg_nxt = 7'b0000000;
    else                 w_seg_nxt = w_pat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init     <= 1'b1;
      r_last_val <= '0;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_scan     <= '0;
      r_digit    <= '0;
      seg        <= '0;
      an         <= '0;
      led_green  <= 1'b0;
      led_yellow <= 1'b0;
      led_red    <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_init     <= w_init_nxt;
      r_last_val <= w_last_nxt;
      r_sh       <= w_sh_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hund     <= w_hund_nxt;
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
      r_scan     <= w_scan_wrap ? '0 : r_scan + CW'(1);
      if (w_scan_wrap) r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
      // an and seg both derive from r_digit, so they always switch together
      seg        <= w_seg_nxt;
      an         <= w_an_nxt;
      led_green  <= (light == 2'b00);
      led_yellow <= (light == 2'b01);
      led_red    <= (light == 2'b10);
      err        <= (light == 2'b11);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_display.sv
`default_nettype none
// tb_traffic_display: randomized self-checking bench against a decimal-arithmetic display model.
module tb_traffic_display;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] timee = 8'd0;
  logic [1:0] light = 2'b00;
  logic [6:0] seg;
  logic [2:0] an;
  logic       led_green, led_yellow, led_red, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  traffic_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .timee(timee), .light(light),
    .seg(seg), .an(an), .led_green(led_green), .led_yellow(led_yellow),
    .led_red(led_red), .err(err)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan position follows directly from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b0111111;  1: pat = 7'b0000110;  2: pat = 7'b1011011;
      3: pat = 7'b1001111;  4: pat = 7'b1100110;  5: pat = 7'b1101101;
      6: pat = 7'b1111101;  7: pat = 7'b0000111;  8: pat = 7'b1111111;
      9: pat = 7'b1101111;  default: pat = 7'b0000000;
    endcase
  endfunction

  function automatic logic [2:0] exp_an(input int c);
    if (c == 0) return 3'b000;
    return 3'b001 << (((c - 1) / SD) % 3);
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int c, input logic [1:0] lt);
    int pos;
    if (c == 0) return 7'b0000000;
    pos = ((c - 1) / SD) % 3;
    if (lt == 2'b11) return 7'b1111001;
    case (pos)
      0:       return pat(v % 10);
      1:       return (v < 10)  ? 7'b0000000 : pat((v / 10) % 10);
      default: return (v < 100) ? 7'b0000000 : pat(v / 100);
    endcase
  endfunction

  // {err, red, yellow, green}
  function automatic logic [3:0] exp_lamp(input logic [1:0] lt);
    case (lt)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic test_reset();
    timee = 8'd30;
    light = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({seg, an, led_red, led_yellow, led_green, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_async outputs=%b expected=%b", {seg, an, led_red, led_yellow, led_green, err}, 14'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({seg, an, led_red, led_yellow, led_green, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_held outputs=%b expected=%b", {seg, an, led_red, led_yellow, led_green, err}, 14'd0);
    end
  endtask

  task automatic test_basic();
    int cnt[3];
    cnt = '{0, 0, 0};
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (11) @(posedge clk);
    for (int i = 0; i < 3 * SD; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg(30, cyc, 2'b00)) begin
        errors++;
        $display("FAIL basic_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg(30, cyc, 2'b00));
      end
      checks++;
      if (an !== exp_an(cyc)) begin
        errors++;
        $display("FAIL basic_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc));
      end
      checks++;
      if ({err, led_red, led_yellow, led_green} !== 4'b0001) begin
        errors++;
        $display("FAIL basic_lamp got=%b exp=0001", {err, led_red, led_yellow, led_green});
      end
      for (int b = 0; b < 3; b++) if (an[b]) cnt[b]++;
      @(posedge clk);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (cnt[b] != SD) begin
        errors++;
        $display("FAIL basic_an_dwell digit=%0d got=%0d exp=%0d", b, cnt[b], SD);
      end
    end
  endtask

  task automatic test_values();
    int v;
    logic [1:0] lt;
    for (int k = 0; k < 11; k++) begin
      case (k)
        0:       v = 255;
        1:       v = 100;
        2:       v = 5;
        default: v = $urandom_range(0, 255);
      endcase
      lt = (k < 3) ? 2'b00 : 2'($urandom_range(0, 2));
      @(posedge clk);
      #1 timee = 8'(v);
      light = lt;
      repeat (12) @(posedge clk);
      for (int i = 0; i < 3 * SD; i++) begin
        @(negedge clk);
        checks++;
        if (seg !== exp_seg(v, cyc, lt)) begin
          errors++;
          $display("FAIL values_seg v=%0d cyc=%0d got=%b exp=%b", v, cyc, seg, exp_seg(v, cyc, lt));
        end
        checks++;
        if (an !== exp_an(cyc)) begin
          errors++;
          $display("FAIL values_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc));
        end
        checks++;
        if ({err, led_red, led_yellow, led_green} !== exp_lamp(lt)) begin
          errors++;
          $display("FAIL values_lamp light=%b got=%b exp=%b", lt, {err, led_red, led_yellow, led_green}, exp_lamp(lt));
        end
        @(posedge clk);
      end
    end
  endtask

  task automatic test_midconv();
    int ev;
    @(posedge clk);
    #1 timee = 8'd0;
    light = 2'b00;
    repeat (15) @(posedge clk);
    #1 timee = 8'd60;
    @(posedge clk);               // E0 samples 60
    repeat (3) @(posedge clk);    // E1..E3
    #1 timee = 8'd59;
    for (int e = 4; e <= 31; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e >= 9) begin
        ev = (e == 9) ? 0 : (e < 20) ? 60 : 59;
        checks++;
        if (seg !== exp_seg(ev, cyc, 2'b00)) begin
          errors++;
          $display("FAIL midconv_seg edge=E%0d exp_val=%0d got=%b exp=%b", e, ev, seg, exp_seg(ev, cyc, 2'b00));
        end
      end
    end
  endtask

  task automatic test_light();
    logic [1:0] seq[5];
    logic [1:0] prev;
    seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    @(posedge clk);
    #1 timee = 8'd42;
    light = 2'b00;
    prev = 2'b00;
    repeat (12) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      #1 light = seq[k];
      @(negedge clk);
      checks++;
      if ({err, led_red, led_yellow, led_green} !== exp_lamp(prev)) begin
        errors++;
        $display("FAIL light_latency step=%0d got=%b exp=%b", k, {err, led_red, led_yellow, led_green}, exp_lamp(prev));
      end
      for (int i = 0; i < 3 * SD; i++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({err, led_red, led_yellow, led_green} !== exp_lamp(seq[k])) begin
          errors++;
          $display("FAIL light_lamp step=%0d got=%b exp=%b", k, {err, led_red, led_yellow, led_green}, exp_lamp(seq[k]));
        end
        checks++;
        if (seg !== exp_seg(42, cyc, seq[k]) || an !== exp_an(cyc)) begin
          errors++;
          $display("FAIL light_display step=%0d seg=%b an=%b exp_seg=%b exp_an=%b", k, seg, an, exp_seg(42, cyc, seq[k]), exp_an(cyc));
        end
      end
      prev = seq[k];
      @(posedge clk);
    end
  endtask

  task automatic test_reset_midconv();
    @(posedge clk);
    #1 timee = 8'd100;
    light = 2'b00;
    repeat (12) @(posedge clk);
    #1 timee = 8'd3;
    @(posedge clk);   // E0
    @(posedge clk);   // E1, converting
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({seg, an, led_red, led_yellow, led_green, err} !== 14'd0) begin
      errors++;
      $display("FAIL rstmid_async outputs=%b expected=%b", {seg, an, led_red, led_yellow, led_green, err}, 14'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (11) @(posedge clk);
    for (int i = 0; i < 3 * SD; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg(3, cyc, 2'b00) || an !== exp_an(cyc)) begin
        errors++;
        $display("FAIL rstmid_display cyc=%0d seg=%b an=%b exp_seg=%b exp_an=%b", cyc, seg, an, exp_seg(3, cyc, 2'b00), exp_an(cyc));
      end
      @(posedge clk);
    end
  endtask

  task automatic test_countdown();
    logic ok;
    for (int v = 3; v >= 0; v--) begin
      @(posedge clk);
      #1 timee = 8'(v);
      light = 2'b10;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b0;
        for (int d = 0; d < 10; d++) if (seg === pat(d)) ok = 1'b1;
        if (seg === 7'b0000000 && exp_an(cyc) != 3'b001) ok = 1'b1;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL countdown_valid v=%0d cyc=%0d got=%b an=%b", v, cyc, seg, an);
        end
        if (i >= 10) begin
          checks++;
          if (seg !== exp_seg(v, cyc, 2'b10) || {err, led_red, led_yellow, led_green} !== 4'b0100) begin
            errors++;
            $display("FAIL countdown_seg v=%0d cyc=%0d got=%b exp=%b lamps=%b", v, cyc, seg, exp_seg(v, cyc, 2'b10), {err, led_red, led_yellow, led_green});
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_midconv();
    test_light();
    test_reset_midconv();
    test_countdown();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached=%0t limit=%0d", $time, 200000);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
